// File: rtl/rv_div_seq_pkg.sv
// rtl/rv_div_seq_pkg.sv - shared types and helpers for the iterative RV32 divider
package rv_div_seq_pkg;

    localparam int DIV_XLEN      = 32;
    localparam int DIV_ITER_BITS = 1;
    localparam int DIV_CNT_W     = $clog2(DIV_XLEN / DIV_ITER_BITS);

    // Encodings follow funct3[1:0] of the M-extension divide group (funct3[2]=1).
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CALC  = 2'b01,
        ST_FIXUP = 2'b10,
        ST_DONE  = 2'b11
    } div_state_t;

    // Codes outside the divide group fall back to DIVU.
    function automatic div_op_t div_decode(input logic [2:0] funct3);
        div_op_t op;
        op = funct3[2] ? div_op_t'(funct3[1:0]) : OP_DIVU;
        return op;
    endfunction

    function automatic logic div_is_signed(input div_op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic div_is_rem(input div_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/rv_div_seq_if.sv
// rtl/rv_div_seq_if.sv - ALU-stage request/response bundle of the divide sequencer
interface rv_div_seq_if #(
    parameter int XLEN = 32
);
    logic            i_flush;
    logic            i_start;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_dividend;
    logic [XLEN-1:0] i_divisor;
    logic            o_stall;
    logic            o_busy;
    logic            o_valid;
    logic [XLEN-1:0] o_result;

    modport master (
        output i_flush, i_start, i_funct3, i_dividend, i_divisor,
        input  o_stall, o_busy, o_valid, o_result
    );

    modport slave (
        input  i_flush, i_start, i_funct3, i_dividend, i_divisor,
        output o_stall, o_busy, o_valid, o_result
    );
endinterface

// File: rtl/rv_div_step.sv
// rtl/rv_div_step.sv - one combinational restoring-division iteration
module rv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    // The extra top bit of diff is the borrow: set means the trial subtract failed.
    always_comb begin
        rem_sh = {i_rem, i_quo[XLEN-1]};
        diff   = rem_sh - {1'b0, i_divisor};
        if (!diff[XLEN]) begin
            o_rem = diff[XLEN-1:0];
            o_quo = {i_quo[XLEN-2:0], 1'b1};
        end else begin
            o_rem = rem_sh[XLEN-1:0];
            o_quo = {i_quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/rv_div_seq.sv
// rtl/rv_div_seq.sv - iterative DIV/DIVU/REM/REMU sequencer that stalls the pipeline while busy
module rv_div_seq
    import rv_div_seq_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ITER_BITS = 1
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    rv_div_seq_if.slave bus
);

    localparam int N     = XLEN / ITER_BITS;
    localparam int CNT_W = $clog2(N);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      state_q,  state_d;
    div_op_t         op_q,     op_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [XLEN-1:0] rem_q,    rem_d;
    logic [XLEN-1:0] quo_q,    quo_d;
    logic [XLEN-1:0] dvs_q,    dvs_d;
    logic            q_neg_q,  q_neg_d;
    logic            r_neg_q,  r_neg_d;
    logic [XLEN-1:0] result_q, result_d;

    div_op_t         op_new;
    logic            sgn_new;
    logic            sa;
    logic            sb;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    logic [XLEN-1:0] rem_chain [ITER_BITS+1];
    logic [XLEN-1:0] quo_chain [ITER_BITS+1];

    assign rem_chain[0] = rem_q;
    assign quo_chain[0] = quo_q;

    for (genvar k = 0; k < ITER_BITS; k++) begin : g_step
        rv_div_step #(.XLEN(XLEN)) u_step (
            .i_rem     (rem_chain[k]),
            .i_quo     (quo_chain[k]),
            .i_divisor (dvs_q),
            .o_rem     (rem_chain[k+1]),
            .o_quo     (quo_chain[k+1])
        );
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;

        op_new  = div_decode(bus.i_funct3);
        sgn_new = div_is_signed(op_new);
        sa      = sgn_new & bus.i_dividend[XLEN-1];
        sb      = sgn_new & bus.i_divisor[XLEN-1];
        quo_fix = q_neg_q ? XLEN'(-quo_q) : quo_q;
        rem_fix = r_neg_q ? XLEN'(-rem_q) : rem_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_start && !bus.i_flush) begin
                    op_d    = op_new;
                    q_neg_d = sa ^ sb;
                    r_neg_d = sa;
                    quo_d   = sa ? XLEN'(-bus.i_dividend) : bus.i_dividend;
                    dvs_d   = sb ? XLEN'(-bus.i_divisor) : bus.i_divisor;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(N - 1);
                    // Zero divisor and signed overflow skip the iteration entirely.
                    if (bus.i_divisor == '0) begin
                        state_d  = ST_DONE;
                        result_d = div_is_rem(op_new) ? bus.i_dividend : '1;
                    end else if (sgn_new && (bus.i_dividend == MIN_NEG) &&
                                 (bus.i_divisor == '1)) begin
                        state_d  = ST_DONE;
                        result_d = div_is_rem(op_new) ? '0 : MIN_NEG;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                rem_d = rem_chain[ITER_BITS];
                quo_d = quo_chain[ITER_BITS];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                result_d = div_is_rem(op_q) ? rem_fix : quo_fix;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase

        // A flush abandons the op and leaves the last delivered result in place.
        if (bus.i_flush) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_DIVU;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
        end
    end

    // During reset the outputs look like an idle unit with i_start ignored.
    assign bus.o_busy   = i_reset_n && (state_q != ST_IDLE);
    assign bus.o_valid  = i_reset_n && (state_q == ST_DONE) && !bus.i_flush;
    assign bus.o_stall  = i_reset_n && !bus.i_flush &&
                          (((state_q == ST_IDLE) && bus.i_start) ||
                           (state_q == ST_CALC) || (state_q == ST_FIXUP));
    assign bus.o_result = result_q;

endmodule
